multi_chan_edge_timer: RTL and testbench
========================================

Name: multi_chan_edge_timer

Overview:
Synchronous, parametrised successor to the single-channel ring-oscillator timer. It measures CHANNELS independent input signals in units of clk cycles. Four modes are supported: high width, low width, period, and edge count per window. Each channel has saturation, a valid/overrun status with an acknowledge handshake, and an 8-bit byte-select readout port that matches the existing 8-bit `out` convention.

Parameters:
- CHANNELS, 4: number of measured inputs (1..16).
- CNT_WIDTH, 16: counter/capture width, multiple of 8 (8..32).
- SYNC_STAGES, 2: input synchroniser depth (>=2).
- WIN_LOG2, 8: event-count window length is 2^WIN_LOG2 clk cycles.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global run; low forces all channels to IDLE.
- mode  in  2  0=high width, 1=low width, 2=period, 3=edge count.
- signal  in  CHANNELS  asynchronous inputs to measure.
- ack  in  CHANNELS  per-channel pulse; clears valid and overrun.
- sel_chan  in  clog2(CHANNELS) (min 1)  readout channel.
- sel_byte  in  clog2(CNT_WIDTH/8) (min 1)  readout byte, 0 = LSB.
- out  out  8  registered readout byte.
- valid  out  CHANNELS  capture available.
- overrun  out  CHANNELS  sticky: a capture overwrote an unacknowledged one.
- saturated  out  CHANNELS  last capture hit all-ones.

Behaviour:
- Reset: all outputs 0; every counter, capture, sync flop and window counter 0; every FSM in IDLE.
- Input path: each signal bit passes SYNC_STAGES flops (s), plus one history flop (p).
  - rise = s & ~p; fall = ~s & p.
  - Edge latency from pin to detect is SYNC_STAGES+1 cycles.
- Per-channel FSM: IDLE -> ARMED -> MEASURE.
  - IDLE -> ARMED when enable=1.
  - Any cycle with enable=0 or a mode change (mode registered, compared with the previous cycle): go to IDLE, clear the counter. Capture, valid and overrun are retained.
  - Start edge: rise for modes 0/2, fall for mode 1. Stop edge: fall for mode 0, rise for modes 1/2.
  - ARMED: on start edge, cnt<=1, go to MEASURE.
  - MEASURE: each cycle without a stop edge, cnt<=cnt+1, saturating at all-ones.
  - MEASURE, on stop edge: cap<=cnt, set valid, set saturated=(cnt==all-ones).
    - Modes 0/1: return to ARMED.
    - Mode 2: stop edge is also a start edge; cnt<=1 and stay in MEASURE.
  - Result: a synchronised high pulse of H cycles captures H; a period of P cycles captures P.
- Mode 3 (edge count):
  - A shared window counter runs while enable=1 and mode=3.
  - The channel counter increments (saturating) on each rise.
  - On the terminal window cycle: cap<=cnt+rise, counter restarts at 0, valid set.
  - An edge on the terminal cycle counts into the closing window.
- Handshake:
  - Capture while valid=1 and no ack that cycle: new data overwrites, overrun<=1.
  - ack alone: valid<=0, overrun<=0.
  - ack and capture in the same cycle: capture wins; valid=1, overrun=0.
- Readout: out <= cap[sel_chan][8*sel_byte +: 8], with one cycle latency.
  - sel_chan >= CHANNELS reads 0; an out-of-range sel_byte reads 0.
- Counters never wrap; they saturate at all-ones.

Decomposition:
- Package multi_chan_edge_timer_pkg holds:
  - mode encodings MODE_HIGH/MODE_LOW/MODE_PERIOD/MODE_COUNT;
  - FSM state enum ST_IDLE/ST_ARMED/ST_MEASURE;
  - saturating-increment function.
- Sub-module edge_timer_channel, instantiated CHANNELS times, contains: synchroniser, edge detect, FSM, counter, capture, and status flags.
- The top level holds the window counter, mode register and readout mux.

Test Plan:
1. Reset.
   - rst pulse mid-measurement on ch0 -> all outputs 0 immediately; after release with enable=1, ch0 waits for a fresh start edge.
2. Mode 0, high width.
   - ch1 high 37 cycles -> valid[1]=1 exactly SYNC_STAGES+1 cycles after the falling pin edge.
   - sel_chan=1, sel_byte=0 -> out=0x25 one cycle later; sel_byte=1 -> out=0x00.
3. Mode 2, period.
   - ch2 square wave period 300 -> cap=300 (bytes 0x2C, 0x01) each period.
   - No ack -> overrun[2]=1 after the second capture.
   - ack pulse -> valid[2]=0, overrun[2]=0.
   - ack coincident with a capture -> valid stays 1, overrun 0.
4. Saturation.
   - Mode 1, ch3 held low 70000 cycles then high -> cap=0xFFFF, saturated[3]=1.
5. Mode 3, edge count.
   - WIN_LOG2=8, 10 rises on ch0 inside the window -> cap=10.
   - Extra rise on the terminal cycle -> cap=11; the next window starts at 0.
6. Abort.
   - enable dropped, or mode changed, mid-MEASURE -> no capture; previous cap/valid retained; the channel re-arms and measures correctly afterwards.

Source files
------------

// File: rtl/multi_chan_edge_timer_pkg.sv
// Shared encodings and helpers for the multi-channel edge timer.
package multi_chan_edge_timer_pkg;

  typedef enum logic [1:0] {
    MODE_HIGH   = 2'd0,
    MODE_LOW    = 2'd1,
    MODE_PERIOD = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE
  } state_e;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/multi_chan_edge_timer_channel.sv
// One measurement channel: synchroniser, edge detect, measurement FSM,
// saturating counter, capture register and valid/overrun/saturated flags.
module edge_timer_channel
  import multi_chan_edge_timer_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [1:0]           mode,
  input  logic                 win_term,
  input  logic                 sig,
  input  logic                 ack,
  output logic [CNT_WIDTH-1:0] cap,
  output logic                 valid,
  output logic                 overrun,
  output logic                 saturated
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   cap_q, cap_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   sat_q, sat_d;

  logic                   rise, fall, start_edge, stop_edge;
  logic                   cap_evt;
  logic [CNT_WIDTH-1:0]   cap_val, cnt_inc;

  assign rise       = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall       = ~sync_q[SYNC_STAGES-1] & hist_q;
  assign start_edge = (mode == MODE_LOW)  ? fall : rise;
  assign stop_edge  = (mode == MODE_HIGH) ? fall : rise;
  assign cnt_inc    = CNT_WIDTH'(sat_inc(32'(cnt_q), 32'(CNT_ONES)));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig};
    hist_d    = sync_q[SYNC_STAGES-1];
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_evt   = 1'b0;
    cap_val   = cnt_q;

    if (!run) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (mode == MODE_COUNT) begin
      // Edges on the terminal window cycle belong to the window that is closing.
      state_d = ST_ARMED;
      cap_val = rise ? cnt_inc : cnt_q;
      if (win_term) begin
        cap_evt = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d   = cap_val;
      end
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: begin
          if (start_edge) begin
            cnt_d   = CNT_WIDTH'(1);
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (stop_edge) begin
            cap_evt = 1'b1;
            if (mode == MODE_PERIOD) cnt_d = CNT_WIDTH'(1);
            else                     state_d = ST_ARMED;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end

    cap_d     = cap_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    sat_d     = sat_q;
    if (cap_evt) begin
      cap_d     = cap_val;
      valid_d   = 1'b1;
      overrun_d = ~ack & (overrun_q | valid_q);
      sat_d     = (cap_val == CNT_ONES);
    end else if (ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cap_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      sat_q     <= sat_d;
    end
  end

  assign cap       = cap_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign saturated = sat_q;

endmodule

// File: rtl/multi_chan_edge_timer.sv
// Multi-channel edge timer top: mode register, shared count window and
// registered byte-select readout over CHANNELS measurement channels.
module multi_chan_edge_timer
  import multi_chan_edge_timer_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WIN_LOG2    = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               enable,
  input  logic [1:0]                                         mode,
  input  logic [CHANNELS-1:0]                                signal,
  input  logic [CHANNELS-1:0]                                ack,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel_chan,
  input  logic [((CNT_WIDTH > 8) ? $clog2(CNT_WIDTH/8) : 1)-1:0] sel_byte,
  output logic [7:0]                                         out,
  output logic [CHANNELS-1:0]                                valid,
  output logic [CHANNELS-1:0]                                overrun,
  output logic [CHANNELS-1:0]                                saturated
);

  localparam int NBYTES = CNT_WIDTH / 8;

  logic [1:0]           mode_q, mode_d;
  logic [WIN_LOG2-1:0]  win_q, win_d;
  logic [7:0]           out_q, out_d;
  logic                 mode_chg, run, win_run, win_term;
  logic [CNT_WIDTH-1:0] cap [CHANNELS];

  // A mode change aborts every channel for one cycle, exactly like enable low.
  assign mode_chg = (mode != mode_q);
  assign run      = enable & ~mode_chg;
  assign win_run  = run & (mode_q == MODE_COUNT);
  assign win_term = win_run & (&win_q);

  always_comb begin
    mode_d = mode;
    win_d  = win_run ? win_q + WIN_LOG2'(1) : '0;
    out_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (int'(sel_chan) == c && int'(sel_byte) == b) out_d = cap[c][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      win_q  <= '0;
      out_q  <= '0;
    end else begin
      mode_q <= mode_d;
      win_q  <= win_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    edge_timer_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .mode      (mode_q),
      .win_term  (win_term),
      .sig       (signal[c]),
      .ack       (ack[c]),
      .cap       (cap[c]),
      .valid     (valid[c]),
      .overrun   (overrun[c]),
      .saturated (saturated[c])
    );
  end

endmodule

// File: tb/tb_multi_chan_edge_timer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a timestamp-based reference model of the timer.
module tb_multi_chan_edge_timer;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int WIN  = 256;
  localparam int CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [CH-1:0] signal;
  logic [CH-1:0] ack;
  logic [1:0]    sel_chan;
  logic [0:0]    sel_byte;
  logic [7:0]    out;
  logic [CH-1:0] valid, overrun, saturated;

  multi_chan_edge_timer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mode      (mode),
    .signal    (signal),
    .ack       (ack),
    .sel_chan  (sel_chan),
    .sel_byte  (sel_byte),
    .out       (out),
    .valid     (valid),
    .overrun   (overrun),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;

  // Reference model: pin delay line, per-channel phase and start timestamp.
  bit [SS:0]  hist     [CH];
  int         m_phase  [CH];   // 0 idle, 1 waiting for start, 2 measuring
  longint     t_start  [CH];
  int         rise_cnt [CH];
  int         m_cap    [CH];
  bit         m_valid  [CH];
  bit         m_over   [CH];
  bit         m_sat    [CH];
  longint     k;
  longint     win_start;
  int         prev_mode;
  logic [7:0] exp_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      hist[c]     = '0;
      m_phase[c]  = 0;
      t_start[c]  = 0;
      rise_cnt[c] = 0;
      m_cap[c]    = 0;
      m_valid[c]  = 1'b0;
      m_over[c]   = 1'b0;
      m_sat[c]    = 1'b0;
    end
    prev_mode = 0;
    win_start = -1;
    exp_out   = 8'h00;
  endtask

  task automatic model_step();
    bit run, term, s, p, rise, fall, start, stop, cap_now;
    int md, val;
    longint width;
    if (rst) begin
      model_reset();
      return;
    end
    md      = int'(mode);
    val     = m_cap[sel_chan];
    exp_out = 8'(val >> (8 * sel_byte));
    run     = enable && (md == prev_mode);
    term    = 1'b0;
    if (run && md == 3) begin
      if (win_start < 0) win_start = k;
      term = ((k - win_start) % WIN) == WIN - 1;
    end else begin
      win_start = -1;
    end
    for (int c = 0; c < CH; c++) begin
      s       = hist[c][SS-1];
      p       = hist[c][SS];
      rise    = s & ~p;
      fall    = ~s & p;
      start   = (md == 1) ? fall : rise;
      stop    = (md == 0) ? fall : rise;
      cap_now = 1'b0;
      val     = 0;
      if (!run) begin
        m_phase[c]  = 0;
        rise_cnt[c] = 0;
      end else if (md == 3) begin
        m_phase[c]  = 1;
        rise_cnt[c] += int'(rise);
        if (term) begin
          cap_now     = 1'b1;
          val         = (rise_cnt[c] > CMAX) ? CMAX : rise_cnt[c];
          rise_cnt[c] = 0;
        end
      end else if (m_phase[c] == 0) begin
        m_phase[c] = 1;
      end else if (m_phase[c] == 1) begin
        if (start) begin
          t_start[c] = k;
          m_phase[c] = 2;
        end
      end else if (stop) begin
        width   = k - t_start[c];
        cap_now = 1'b1;
        val     = (width > CMAX) ? CMAX : int'(width);
        if (md == 2) t_start[c] = k;
        else         m_phase[c] = 1;
      end
      if (cap_now) begin
        m_over[c]  = ack[c] ? 1'b0 : (m_over[c] | m_valid[c]);
        m_valid[c] = 1'b1;
        m_cap[c]   = val;
        m_sat[c]   = (val == CMAX);
      end else if (ack[c]) begin
        m_valid[c] = 1'b0;
        m_over[c]  = 1'b0;
      end
      hist[c] = {hist[c][SS-1:0], signal[c]};
    end
    prev_mode = md;
    k++;
  endtask

  task automatic check_all();
    logic [3*CH-1:0] exp_st;
    for (int c = 0; c < CH; c++) begin
      exp_st[c]        = m_valid[c];
      exp_st[CH + c]   = m_over[c];
      exp_st[2*CH + c] = m_sat[c];
    end
    check("status", 32'({saturated, overrun, valid}), 32'(exp_st));
    check("out", 32'(out), 32'(exp_out));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tick_until(input longint mark, input longint target);
    while (cyc - mark < target) tick();
  endtask

  task automatic read_cap(input int ch, output int val);
    sel_chan = 2'(ch);
    sel_byte = 1'b0;
    tick();
    val      = int'(out);
    sel_byte = 1'b1;
    tick();
    val      = val | (int'(out) << 8);
    sel_byte = 1'b0;
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    signal[ch] = 1'b1;
    ticks(hi);
    signal[ch] = 1'b0;
    ticks(lo);
  endtask

  initial begin
    int     v;
    longint mark;
    rst      = 1'b1;
    enable   = 1'b0;
    mode     = 2'd0;
    signal   = '0;
    ack      = '0;
    sel_chan = 2'd0;
    sel_byte = 1'b0;
    k        = 0;
    model_reset();
    #1;
    check("reset_status", 32'({saturated, overrun, valid}), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    ticks(3);
    rst = 1'b0;

    // Reset in the middle of a measurement on ch0.
    enable = 1'b1;
    ticks(3);
    pulse(0, 15, 5);
    check("pre_rst_valid0", 32'(valid[0]), 32'd1);
    signal[0] = 1'b1;
    ticks(10);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_status", 32'({saturated, overrun, valid}), 32'd0);
    check("rst_async_out", 32'(out), 32'd0);
    signal[0] = 1'b0;
    ticks(2);
    rst = 1'b0;
    ticks(10);
    check("rst_no_capture", 32'(valid[0]), 32'd0);
    pulse(0, 20, 5);
    read_cap(0, v);
    check("rst_fresh_cap", 32'(v), 32'd20);

    // High width on ch1 with detect latency.
    signal[1] = 1'b1;
    ticks(37);
    signal[1] = 1'b0;
    ticks(2);
    check("lat_before", 32'(valid[1]), 32'd0);
    tick();
    check("lat_at", 32'(valid[1]), 32'd1);
    sel_chan = 2'd1;
    sel_byte = 1'b0;
    tick();
    check("hw_byte0", 32'(out), 32'h25);
    sel_byte = 1'b1;
    tick();
    check("hw_byte1", 32'(out), 32'h00);
    sel_byte = 1'b0;
    ack[1]   = 1'b1;
    tick();
    ack[1]   = 1'b0;

    // Period on ch2, overrun and ack handshake.
    mode = 2'd2;
    ticks(3);
    for (int i = 0; i < 3; i++) pulse(2, 150, 150);
    check("per_overrun", 32'(overrun[2]), 32'd1);
    sel_chan = 2'd2;
    tick();
    check("per_byte0", 32'(out), 32'h2C);
    sel_byte = 1'b1;
    tick();
    check("per_byte1", 32'(out), 32'h01);
    sel_byte = 1'b0;
    ack[2]   = 1'b1;
    tick();
    ack[2]   = 1'b0;
    check("ack_valid", 32'(valid[2]), 32'd0);
    check("ack_overrun", 32'(overrun[2]), 32'd0);
    pulse(2, 150, 150);
    signal[2] = 1'b1;
    ticks(2);
    ack[2]    = 1'b1;
    tick();
    ack[2]    = 1'b0;
    check("ack_cap_valid", 32'(valid[2]), 32'd1);
    check("ack_cap_overrun", 32'(overrun[2]), 32'd0);
    ticks(147);
    signal[2] = 1'b0;
    ticks(150);

    // Saturation: ch3 low for longer than the counter range in low-width mode.
    signal[3] = 1'b1;
    mode      = 2'd1;
    ticks(5);
    signal[3] = 1'b0;
    ticks(70000);
    signal[3] = 1'b1;
    ticks(5);
    read_cap(3, v);
    check("sat_cap", 32'(v), 32'hFFFF);
    check("sat_flag", 32'(saturated[3]), 32'd1);

    // Edge count windows on ch0.
    mode = 2'd3;
    mark = cyc;
    tick();
    for (int i = 0; i < 10; i++) pulse(0, 3, 3);
    tick_until(mark, 258);
    read_cap(0, v);
    check("cnt_win1", 32'(v), 32'd10);
    for (int i = 0; i < 10; i++) pulse(0, 3, 3);
    tick_until(mark, 510);
    signal[0] = 1'b1;
    tick();
    tick_until(mark, 514);
    read_cap(0, v);
    check("cnt_win2_term", 32'(v), 32'd11);
    signal[0] = 1'b0;
    tick_until(mark, 770);
    read_cap(0, v);
    check("cnt_win3_empty", 32'(v), 32'd0);

    // Aborts on ch1: enable drop, then mode change, mid-measurement.
    mode = 2'd0;
    ticks(3);
    pulse(1, 25, 5);
    read_cap(1, v);
    check("abort_ref_cap", 32'(v), 32'd25);
    signal[1] = 1'b1;
    ticks(20);
    enable    = 1'b0;
    tick();
    enable    = 1'b1;
    ticks(10);
    signal[1] = 1'b0;
    ticks(5);
    check("abort_en_valid", 32'(valid[1]), 32'd1);
    read_cap(1, v);
    check("abort_en_cap", 32'(v), 32'd25);
    pulse(1, 33, 5);
    read_cap(1, v);
    check("rearm_en_cap", 32'(v), 32'd33);
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0;
    signal[1] = 1'b1;
    ticks(10);
    mode = 2'd2;
    tick();
    mode = 2'd0;
    ticks(10);
    signal[1] = 1'b0;
    ticks(5);
    check("abort_mode_valid", 32'(valid[1]), 32'd0);
    pulse(1, 12, 5);
    read_cap(1, v);
    check("rearm_mode_cap", 32'(v), 32'd12);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) signal[c] = ~signal[c];
        ack[c] = ($urandom_range(0, 15) == 0);
      end
      sel_chan = 2'($urandom_range(0, 3));
      sel_byte = 1'($urandom_range(0, 1));
      enable   = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 499) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end
    ack = '0;
    ticks(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
